// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet MAC transmit framer: preamble, SFD, body, optional pad, FCS and inter-frame gap.
// Define ETH_TX_AUTO_PAD_EN to pad short bodies with zeros up to the 64-byte minimum frame.
module eth_tx_framer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PREAMBLE_LEN   = 7,
  parameter int MIN_FRAME_SIZE = 64,
  parameter int MAX_FRAME_SIZE = 1518,
  parameter int IFG_BYTES      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_en,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_underrun,
  output logic                  err_oversize
);

`ifdef ETH_TX_AUTO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [10:0] BODY_MIN = 11'(MIN_FRAME_SIZE - 4);
  localparam logic [10:0] BODY_MAX = 11'(MAX_FRAME_SIZE - 4);
  localparam logic [4:0]  PRE_LAST = 5'(PREAMBLE_LEN - 1);
  // The IDLE cycle and the first PRE cycle (tx_en still low) complete the gap,
  // so back-to-back frames see exactly IFG_BYTES idle line cycles.
  localparam logic [4:0]  IFG_LAST = 5'(IFG_BYTES - 2);
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, DRAIN, FCS, IFG} state_t;

  state_t                  state, state_nxt;
  logic [4:0]              cnt, cnt_nxt;
  logic [31:0]             crc, crc_nxt;
  logic [10:0]             byte_cnt, byte_cnt_nxt;
  logic [DATA_WIDTH-1:0]   tx_data_nxt;
  logic                    tx_en_nxt, done_nxt, underrun_nxt, oversize_nxt;
  logic [31:0]             fcs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [DATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c ^ {{(32-DATA_WIDTH){1'b0}}, d};
    for (int i = 0; i < DATA_WIDTH; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign s_ready = (state == DATA) || (state == DRAIN);
  assign busy    = (state != IDLE);
  assign fcs     = ~crc;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    crc_nxt      = crc;
    byte_cnt_nxt = byte_cnt;
    tx_data_nxt  = '0;
    tx_en_nxt    = 1'b0;
    done_nxt     = 1'b0;
    underrun_nxt = 1'b0;
    oversize_nxt = 1'b0;
    case (state)
      IDLE: begin
        crc_nxt      = CRC_INIT;
        byte_cnt_nxt = '0;
        cnt_nxt      = '0;
        if (s_valid) state_nxt = PRE;
      end
      PRE: begin
        tx_data_nxt = 8'h55;
        tx_en_nxt   = 1'b1;
        if (cnt == PRE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = SFD;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      SFD: begin
        tx_data_nxt = 8'hD5;
        tx_en_nxt   = 1'b1;
        state_nxt   = DATA;
      end
      DATA: begin
        if (!s_valid) begin
          underrun_nxt = 1'b1;
          state_nxt    = DRAIN;
        end else if (byte_cnt >= BODY_MAX) begin
          // A body byte beyond the limit is swallowed; a final one needs no drain.
          oversize_nxt = 1'b1;
          byte_cnt_nxt = BODY_MAX + 11'd1;
          state_nxt    = s_last ? IFG : DRAIN;
        end else begin
          tx_data_nxt  = s_data;
          tx_en_nxt    = 1'b1;
          crc_nxt      = crc_byte(crc, s_data);
          byte_cnt_nxt = byte_cnt + 11'd1;
          if (s_last) state_nxt = (PAD_EN && (byte_cnt + 11'd1 < BODY_MIN)) ? PAD : FCS;
        end
      end
      PAD: begin
        tx_en_nxt    = 1'b1;
        crc_nxt      = crc_byte(crc, '0);
        byte_cnt_nxt = byte_cnt + 11'd1;
        if (byte_cnt + 11'd1 >= BODY_MIN) state_nxt = FCS;
      end
      DRAIN: begin
        if (s_valid && s_last) begin
          cnt_nxt   = '0;
          state_nxt = IFG;
        end
      end
      FCS: begin
        tx_data_nxt = fcs[8*cnt[1:0] +: 8];
        tx_en_nxt   = 1'b1;
        if (cnt[1:0] == 2'd3) begin
          done_nxt     = 1'b1;
          crc_nxt      = CRC_INIT;
          byte_cnt_nxt = '0;
          cnt_nxt      = '0;
          state_nxt    = IFG;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      IFG: begin
        if (cnt == IFG_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      crc          <= CRC_INIT;
      byte_cnt     <= '0;
      tx_data      <= '0;
      tx_en        <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      crc          <= crc_nxt;
      byte_cnt     <= byte_cnt_nxt;
      tx_data      <= tx_data_nxt;
      tx_en        <= tx_en_nxt;
      frame_done   <= done_nxt;
      err_underrun <= underrun_nxt;
      err_oversize <= oversize_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected line bytes are queued as frames are issued,
// and a negedge monitor pops and compares every tx_en byte plus the status pulses.
module tb_eth_tx_framer;
  typedef logic [7:0] u8;
  typedef struct packed { logic [7:0] d; logic last; } exp_t;

`ifdef ETH_TX_AUTO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic s_ready, tx_en, busy, frame_done, err_underrun, err_oversize;
  logic [7:0] tx_data;

  eth_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .tx_data(tx_data), .tx_en(tx_en), .busy(busy),
    .frame_done(frame_done), .err_underrun(err_underrun), .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  bit mon_on = 1'b0;
  bit chk_gap = 1'b0;
  int run_len = 0, last_run = 0, gap = 0;
  int n_done = 0, n_unr = 0, n_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !mon_on) begin
      run_len = 0;
    end else begin
      if (err_underrun) n_unr++;
      if (err_oversize) n_ovr++;
      if (frame_done) n_done++;
      if (err_underrun || err_oversize) check("tx_en_at_error", tx_en, 0);
      if (tx_en) begin
        if (chk_gap && run_len == 0) begin
          check("ifg_gap", gap, 12);
          chk_gap = 1'b0;
        end
        run_len++;
        gap = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_tx_byte", tx_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", tx_data, e.d);
          check("frame_done", frame_done, e.last);
        end
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
        gap++;
        if (frame_done) check("frame_done_idle", frame_done, 0);
      end
    end
  end

  function automatic logic [31:0] crc32(input u8 q[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic int exp_len(input int n);
    return 8 + ((PAD && n < 60) ? 60 : n) + 4;
  endfunction

  task automatic push_byte(input u8 d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_pre();
    for (int i = 0; i < 7; i++) push_byte(8'h55, 1'b0);
    push_byte(8'hD5, 1'b0);
  endtask

  task automatic push_frame_fcs(input u8 body[$], input logic [31:0] f);
    push_pre();
    foreach (body[i]) push_byte(body[i], 1'b0);
    for (int k = 0; k < 4; k++) push_byte(f[8*k +: 8], k == 3);
  endtask

  task automatic push_frame(input u8 body[$]);
    u8 p[$];
    p = body;
    if (PAD) while (p.size() < 60) p.push_back(8'h00);
    push_frame_fcs(p, crc32(p));
  endtask

  task automatic mk(input int n, input int mul, input int add, output u8 q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(u8'(i * mul + add));
  endtask

  task automatic drive_byte(input u8 b, input logic last);
    int g = 0;
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    @(negedge clk);
    while (!s_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!s_ready) check("handshake", s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input u8 body[$]);
    foreach (body[i]) drive_byte(body[i], i == body.size() - 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int g = 0;
    while (busy && g < 4000) begin
      @(negedge clk);
      g++;
    end
    check({name, "_idle"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    u8 b[$];
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {frame_done, err_underrun, err_oversize}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    mon_on = 1'b1;

    // 60-byte body 0x00..0x3B
    mk(60, 1, 0, b);
    push_frame(b);
    send(b);
    wait_idle("f60");
    check("f60_len", last_run, 72);
    check("f60_q", exp_q.size(), 0);
    check("f60_done", n_done, 1);

    // 14-byte body (runt or padded)
    mk(14, 7, 3, b);
    push_frame(b);
    send(b);
    wait_idle("f14");
    check("f14_len", last_run, exp_len(14));
    check("f14_q", exp_q.size(), 0);
    check("f14_done", n_done, 2);

    // "123456789": known CRC-32 0xCBF43926
    b = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    if (PAD) push_frame(b);
    else push_frame_fcs(b, 32'hCBF4_3926);
    send(b);
    wait_idle("f9");
    check("f9_len", last_run, exp_len(9));
    check("f9_q", exp_q.size(), 0);

    // Back-to-back 64-byte bodies
    mk(64, 3, 1, b);
    push_frame(b);
    send(b);
    mk(64, 5, 200, b);
    push_frame(b);
    chk_gap = 1'b1;
    send(b);
    wait_idle("b2b");
    check("b2b_gap_seen", chk_gap, 0);
    check("b2b_len", last_run, 76);
    check("b2b_q", exp_q.size(), 0);
    check("b2b_done", n_done, 5);

    // Underrun after body byte 20, then drain three bytes
    mk(20, 1, 100, b);
    push_pre();
    foreach (b[i]) push_byte(b[i], 1'b0);
    foreach (b[i]) drive_byte(b[i], 1'b0);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("unr_pulse", n_unr, 1);
    check("unr_busy", busy, 1);
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b0);
    drive_byte(8'hCC, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    wait_idle("unr");
    check("unr_len", last_run, 28);
    check("unr_q", exp_q.size(), 0);
    check("unr_done", n_done, 5);

    // Oversize: 1515-byte body
    mk(1515, 1, 9, b);
    push_pre();
    for (int i = 0; i < 1514; i++) push_byte(b[i], 1'b0);
    send(b);
    wait_idle("ovr");
    check("ovr_pulse", n_ovr, 1);
    check("ovr_len", last_run, 1522);
    check("ovr_q", exp_q.size(), 0);
    check("ovr_done", n_done, 5);

    // Maximum legal body: 1514 bytes
    mk(1514, 13, 5, b);
    push_frame(b);
    send(b);
    wait_idle("max");
    check("max_len", last_run, 1526);
    check("max_q", exp_q.size(), 0);
    check("max_done", n_done, 6);
    check("max_no_err", n_unr + n_ovr, 2);

    // Reset in the middle of the body
    mon_on = 1'b0;
    mk(30, 1, 0, b);
    foreach (b[i]) drive_byte(b[i], 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_en", tx_en, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_busy", busy, 0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    mk(60, 1, 0, b);
    push_frame(b);
    send(b);
    wait_idle("after_rst");
    check("after_rst_len", last_run, 72);
    check("after_rst_q", exp_q.size(), 0);
    check("after_rst_done", n_done, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
